// File: rtl/sched_cu.sv
// sched_cu: microcoded sequencer for the scheduled FPU datapaths.
// Steps through a writable control-word store and repeats the schedule a
// programmable number of times. Supports stall and abort, and uses a go/done
// handshake.
module sched_cu #(
  parameter int unsigned     STEPS     = 8,
  parameter int unsigned     CW        = 15,
  parameter int unsigned     ITER_W    = 8,
  parameter logic [CW-1:0]   IDLE_CTRL = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      go,
  input  logic [ITER_W-1:0]         iters,
  input  logic                      stall,
  input  logic                      abort,
  input  logic                      ucode_we,
  input  logic [$clog2(STEPS)-1:0]  ucode_addr,
  input  logic [CW-1:0]             ucode_data,
  output logic [CW-1:0]             ctrl,
  output logic [$clog2(STEPS)-1:0]  step,
  output logic [ITER_W-1:0]         iter,
  output logic                      busy,
  output logic                      done,
  output logic                      wr_err
);

  localparam int unsigned    AW       = $clog2(STEPS);
  localparam logic [AW-1:0]  LastStep = AW'(STEPS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       step_q, step_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [ITER_W-1:0]   last_q, last_d;   // index of the final pass
  logic                wr_err_q, wr_err_d;
  logic [CW-1:0]       store_q [STEPS];
  logic                wr_ok;

  // Store writes are only legal while idle and in range.
  always_comb begin
    wr_ok    = ucode_we && (state_q == StIdle) && (32'(ucode_addr) < STEPS);
    wr_err_d = ucode_we && !wr_ok;
  end

  // Next-state logic for the sequencer.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    iter_d  = iter_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (go) begin
          state_d = StRun;
          step_d  = '0;
          iter_d  = '0;
          // A zero count runs one pass.
          last_d  = (iters == '0) ? '0 : iters - 1'b1;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          step_d  = '0;
          iter_d  = '0;
        end else if (!stall) begin
          if (step_q != LastStep) begin
            step_d = step_q + 1'b1;
          end else if (iter_q != last_q) begin
            step_d = '0;
            iter_d = iter_q + 1'b1;
          end else begin
            state_d = StDone;
            step_d  = '0;
            iter_d  = '0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        step_d  = '0;
        iter_d  = '0;
      end
    endcase
  end

  // Sequencer state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      step_q   <= '0;
      iter_q   <= '0;
      last_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      iter_q   <= iter_d;
      last_q   <= last_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Control-word store; cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STEPS); i++) begin
        store_q[i] <= '0;
      end
    end else if (wr_ok) begin
      store_q[ucode_addr] <= ucode_data;
    end
  end

  // Outputs decode from registered state and the store only.
  always_comb begin
    ctrl   = (state_q == StRun) ? store_q[step_q] : IDLE_CTRL;
    step   = step_q;
    iter   = iter_q;
    busy   = (state_q != StIdle);
    done   = (state_q == StDone);
    wr_err = wr_err_q;
  end

endmodule

// File: tb/tb_sched_cu.sv
// Self-checking bench for sched_cu: vector table plus directed sequences.
module tb_sched_cu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [7:0]  iters = '0;
  logic        stall = 1'b0;
  logic        abort = 1'b0;
  logic        ucode_we = 1'b0;
  logic [2:0]  ucode_addr = '0;
  logic [14:0] ucode_data = '0;
  logic [14:0] ctrl;
  logic [2:0]  step;
  logic [7:0]  iter;
  logic        busy, done, wr_err;

  // Second instance with a non-power-of-two store depth.
  logic        go6 = 1'b0;
  logic [7:0]  iters6 = '0;
  logic        zero6 = 1'b0;
  logic        we6 = 1'b0;
  logic [2:0]  addr6 = '0;
  logic [14:0] data6 = '0;
  logic [14:0] ctrl6;
  logic [2:0]  step6;
  logic [7:0]  iter6;
  logic        busy6, done6, wr_err6;

  sched_cu dut (
    .clk(clk), .rst_n(rst_n), .go(go), .iters(iters), .stall(stall), .abort(abort),
    .ucode_we(ucode_we), .ucode_addr(ucode_addr), .ucode_data(ucode_data),
    .ctrl(ctrl), .step(step), .iter(iter), .busy(busy), .done(done), .wr_err(wr_err)
  );

  sched_cu #(.STEPS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .go(go6), .iters(iters6), .stall(zero6), .abort(zero6),
    .ucode_we(we6), .ucode_addr(addr6), .ucode_data(data6),
    .ctrl(ctrl6), .step(step6), .iter(iter6), .busy(busy6), .done(done6), .wr_err(wr_err6)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        go;
    logic [7:0]  iters;
    logic        stall;
    logic        abort;
    logic [14:0] ctrl;
    logic [2:0]  step;
    logic        chk_step;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t        vecs[$];
  int          total = 0;
  int          bad = 0;
  logic [14:0] exp_word [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic g, input logic [7:0] n, input logic s,
                              input logic a, input logic [14:0] c, input logic [2:0] st,
                              input logic cs, input logic b, input logic d);
    vec_t v;
    v.go = g; v.iters = n; v.stall = s; v.abort = a; v.ctrl = c;
    v.step = st; v.chk_step = cs; v.busy = b; v.done = d;
    return v;
  endfunction

  // Start a run of n passes and check every cycle against exp_word.
  task automatic run_seq(input logic [7:0] n, input int passes, input string tag);
    iters = n; go = 1'b1;
    tick();
    go = 1'b0;
    for (int p = 0; p < passes; p++) begin
      for (int s = 0; s < 8; s++) begin
        chk($sformatf("%s ctrl p%0d s%0d", tag, p, s), 32'(ctrl), 32'(exp_word[s]));
        chk($sformatf("%s step p%0d s%0d", tag, p, s), 32'(step), s);
        chk($sformatf("%s iter p%0d s%0d", tag, p, s), 32'(iter), p);
        chk($sformatf("%s run p%0d s%0d", tag, p, s), {busy, done}, 32'b10);
        tick();
      end
    end
    chk({tag, " done"}, {busy, done}, 32'b11);
    chk({tag, " done ctrl"}, 32'(ctrl), 0);
    tick();
    chk({tag, " idle"}, {busy, done}, 32'b00);
  endtask

  initial begin
    int seen;

    // Reset held for two cycles.
    tick();
    tick();
    chk("rst ctrl", 32'(ctrl), 0);
    chk("rst step", 32'(step), 0);
    chk("rst iter", 32'(iter), 0);
    chk("rst busy/done", {busy, done}, 0);
    chk("rst wr_err", 32'(wr_err), 0);
    rst_n = 1'b1;

    // Load store[k] = k+1.
    for (int k = 0; k < 8; k++) begin
      ucode_we = 1'b1; ucode_addr = 3'(k); ucode_data = 15'(k + 1);
      exp_word[k] = 15'(k + 1);
      tick();
      chk($sformatf("load wr_err %0d", k), 32'(wr_err), 0);
    end
    ucode_we = 1'b0;

    // Single pass, with go asserted during DONE (ignored).
    vecs.push_back(mk(1, 8'd1, 0, 0, 15'd1, 3'd0, 1, 1, 0));
    for (int s = 1; s < 8; s++) vecs.push_back(mk(0, 0, 0, 0, 15'(s + 1), 3'(s), 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 15'd0, 3'd0, 0, 1, 1));
    vecs.push_back(mk(1, 8'd5, 0, 0, 15'd0, 3'd0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 15'd0, 3'd0, 1, 0, 0));
    // Stall three cycles at step 4.
    vecs.push_back(mk(1, 8'd1, 0, 0, 15'd1, 3'd0, 1, 1, 0));
    for (int s = 1; s < 5; s++) vecs.push_back(mk(0, 0, 0, 0, 15'(s + 1), 3'(s), 1, 1, 0));
    for (int s = 0; s < 3; s++) vecs.push_back(mk(0, 0, 1, 0, 15'd5, 3'd4, 1, 1, 0));
    for (int s = 5; s < 8; s++) vecs.push_back(mk(0, 0, 0, 0, 15'(s + 1), 3'(s), 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 15'd0, 3'd0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 15'd0, 3'd0, 1, 0, 0));
    // Abort with stall at step 5.
    vecs.push_back(mk(1, 8'd1, 0, 0, 15'd1, 3'd0, 1, 1, 0));
    for (int s = 1; s < 6; s++) vecs.push_back(mk(0, 0, 0, 0, 15'(s + 1), 3'(s), 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 15'd0, 3'd0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 15'd0, 3'd0, 1, 0, 0));
    // Abort in IDLE is ignored.
    vecs.push_back(mk(0, 0, 0, 1, 15'd0, 3'd0, 1, 0, 0));

    foreach (vecs[i]) begin
      go = vecs[i].go; iters = vecs[i].iters; stall = vecs[i].stall; abort = vecs[i].abort;
      tick();
      chk($sformatf("vec%0d ctrl", i), 32'(ctrl), 32'(vecs[i].ctrl));
      if (vecs[i].chk_step) chk($sformatf("vec%0d step", i), 32'(step), 32'(vecs[i].step));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].done));
    end
    go = 1'b0; stall = 1'b0; abort = 1'b0;

    // Repeat count and zero count.
    run_seq(8'd3, 3, "it3");
    run_seq(8'd0, 1, "it0");

    // Write during RUN is dropped.
    iters = 8'd1; go = 1'b1;
    tick();
    go = 1'b0;
    ucode_we = 1'b1; ucode_addr = 3'd2; ucode_data = 15'h55;
    tick();
    ucode_we = 1'b0;
    chk("run wr_err set", 32'(wr_err), 1);
    tick();
    chk("run wr_err clear", 32'(wr_err), 0);
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      if (done) seen = 1;
      else tick();
    end
    chk("run wr done seen", seen, 1);
    tick();
    run_seq(8'd1, 1, "after_wr");

    // STEPS=6 instance: out-of-range write.
    for (int k = 0; k < 6; k++) begin
      we6 = 1'b1; addr6 = 3'(k); data6 = 15'(10 + k);
      tick();
      chk($sformatf("s6 load wr_err %0d", k), 32'(wr_err6), 0);
    end
    addr6 = 3'd7; data6 = 15'h7fff;
    tick();
    we6 = 1'b0;
    chk("s6 oor wr_err set", 32'(wr_err6), 1);
    tick();
    chk("s6 oor wr_err clear", 32'(wr_err6), 0);
    iters6 = 8'd1; go6 = 1'b1;
    tick();
    go6 = 1'b0;
    for (int s = 0; s < 6; s++) begin
      chk($sformatf("s6 ctrl %0d", s), 32'(ctrl6), 10 + s);
      chk($sformatf("s6 step %0d", s), 32'(step6), s);
      tick();
    end
    chk("s6 done", {busy6, done6}, 32'b11);
    tick();
    chk("s6 idle", {busy6, done6}, 32'b00);

    // Reset mid-run at step 3.
    iters = 8'd1; go = 1'b1;
    tick();
    go = 1'b0;
    tick(); tick(); tick();
    chk("mid step", 32'(step), 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid rst ctrl", 32'(ctrl), 0);
    chk("mid rst step", 32'(step), 0);
    chk("mid rst busy/done", {busy, done}, 0);
    tick();
    chk("mid rst no done", {busy, done}, 0);
    for (int k = 0; k < 8; k++) exp_word[k] = '0;
    run_seq(8'd1, 1, "cleared");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
